// File: rtl/zoom_pkg.sv
// Shared encodings for the zoom datapath: algorithm select, image state and debounce FSM states.
package zoom_pkg;

   typedef enum logic [1:0] {
      ALG_NN = 2'd0,
      ALG_PR = 2'd1,
      ALG_DC = 2'd2,
      ALG_BA = 2'd3
   } alg_e;

   typedef enum logic [1:0] {
      DEFAULT  = 2'd0,
      ENLARGED = 2'd1,
      REDUCED  = 2'd2
   } img_state_e;

   typedef enum logic [2:0] {
      ARMING      = 3'd0,
      RELEASED    = 3'd1,
      PRESS_CHK   = 3'd2,
      PRESSED     = 3'd3,
      RELEASE_CHK = 3'd4
   } deb_state_e;

endpackage

// File: rtl/zoom_debounce_channel.sv
// One button channel: 2-flop synchronizer, polarity normalisation, debounce FSM and commit strobe.
// With ZOOM_AUTOREPEAT_EN defined, also exports held_c (channel sitting in PRESSED).
module zoom_debounce_channel
   import zoom_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
   input  logic CLK,
   input  logic RESET,
   input  logic key,
   output logic level,
`ifdef ZOOM_AUTOREPEAT_EN
   output logic held_c,
`endif
   output logic commit
);

   localparam int unsigned CW   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] FULL = CW'(DEBOUNCE_CYCLES);

   logic          sync1;
   logic          sync2;
   logic          p;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_inc;
   deb_state_e    state;

   assign p       = sync2 ^ BTN_ACTIVE_LOW;
   assign cnt_inc = (cnt == FULL) ? cnt : cnt + CW'(1);

`ifdef ZOOM_AUTOREPEAT_EN
   assign held_c = (state == PRESSED);
`endif

   // Count is compared against DEBOUNCE_CYCLES-1 because the current sample completes the run.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         sync1  <= BTN_ACTIVE_LOW;
         sync2  <= BTN_ACTIVE_LOW;
         state  <= ARMING;
         cnt    <= '0;
         level  <= 1'b0;
         commit <= 1'b0;
      end else begin
         sync1  <= key;
         sync2  <= sync1;
         commit <= 1'b0;
         case (state)
            ARMING: begin
               if (p) begin
                  cnt <= '0;
               end else if (cnt >= LAST) begin
                  state <= RELEASED;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            RELEASED: begin
               if (p) begin
                  state <= PRESS_CHK;
                  cnt   <= CW'(1);
               end
            end
            PRESS_CHK: begin
               if (!p) begin
                  state <= RELEASED;
                  cnt   <= '0;
               end else if (cnt >= LAST) begin
                  state  <= PRESSED;
                  level  <= 1'b1;
                  commit <= 1'b1;
                  cnt    <= '0;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            PRESSED: begin
               if (!p) begin
                  state <= RELEASE_CHK;
                  cnt   <= CW'(1);
               end
            end
            RELEASE_CHK: begin
               if (p) begin
                  state <= PRESSED;
                  cnt   <= '0;
               end else if (cnt >= LAST) begin
                  state <= RELEASED;
                  level <= 1'b0;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            default: begin
               state <= ARMING;
               level <= 1'b0;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/zoom_button_conditioner.sv
// Conditions the select and zoom buttons into single-cycle pulses with ENABLE gating and collision arbitration.
// Optional select auto-repeat is built when ZOOM_AUTOREPEAT_EN is defined.
module zoom_button_conditioner
   import zoom_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter bit          BTN_ACTIVE_LOW  = 1'b1,
   parameter int unsigned REPEAT_DELAY    = 25000000,
   parameter int unsigned REPEAT_PERIOD   = 10000000
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       KEY_SELECT,
   input  logic       KEY_ZOOM,
   input  logic       ENABLE,
   output logic       SELECT,
   output logic       zoom_requested,
   output logic [1:0] BTN_LEVEL
);

   if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY == 0 || REPEAT_PERIOD == 0) begin : g_bad_cfg
      $error("zoom_button_conditioner: illegal parameter set");
   end

   logic lvl_sel;
   logic lvl_zoom;
   logic sel_commit;
   logic zoom_commit;
   logic zoom_pend;
   logic sel_req_c;
   logic sel_fire_c;
   logic zoom_cand_c;

`ifdef ZOOM_AUTOREPEAT_EN
   logic sel_held_c;
`endif

   zoom_debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
   ) u_sel (
      .CLK    (CLK),
      .RESET  (RESET),
      .key    (KEY_SELECT),
      .level  (lvl_sel),
`ifdef ZOOM_AUTOREPEAT_EN
      .held_c (sel_held_c),
`endif
      .commit (sel_commit)
   );

   zoom_debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
   ) u_zoom (
      .CLK    (CLK),
      .RESET  (RESET),
      .key    (KEY_ZOOM),
      .level  (lvl_zoom),
`ifdef ZOOM_AUTOREPEAT_EN
      .held_c (),
`endif
      .commit (zoom_commit)
   );

   assign BTN_LEVEL = {lvl_zoom, lvl_sel};

`ifdef ZOOM_AUTOREPEAT_EN
   localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int unsigned HW      = $clog2(RPT_MAX + 1);

   logic [HW-1:0] hold_cnt;
   logic          first_rpt;
   logic          rpt_c;

   // hold_cnt is 0 in the commit cycle, so the first repeat lands REPEAT_DELAY cycles after it.
   assign rpt_c = sel_held_c &&
                  (hold_cnt == (first_rpt ? HW'(REPEAT_DELAY) : HW'(REPEAT_PERIOD)));

   always_ff @(posedge CLK) begin
      if (RESET || !sel_held_c) begin
         hold_cnt  <= '0;
         first_rpt <= 1'b1;
      end else if (rpt_c) begin
         hold_cnt  <= HW'(1);
         first_rpt <= 1'b0;
      end else begin
         hold_cnt <= hold_cnt + HW'(1);
      end
   end

   assign sel_req_c = sel_commit | rpt_c;
`else
   assign sel_req_c = sel_commit;
`endif

   assign sel_fire_c  = sel_req_c & ENABLE;
   assign zoom_cand_c = zoom_pend | (zoom_commit & ENABLE);

   // Select wins a same-cycle collision; zoom is parked for one cycle in zoom_pend.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         SELECT         <= 1'b0;
         zoom_requested <= 1'b0;
         zoom_pend      <= 1'b0;
      end else if (sel_fire_c) begin
         SELECT         <= 1'b1;
         zoom_requested <= 1'b0;
         zoom_pend      <= zoom_cand_c;
      end else begin
         SELECT         <= 1'b0;
         zoom_requested <= zoom_cand_c;
         zoom_pend      <= 1'b0;
      end
   end

endmodule

// File: tb/tb_zoom_button_conditioner.sv
// Bench for zoom_button_conditioner: scenario tasks plus random stimulus against a run-length reference model.
module tb_zoom_button_conditioner;

   localparam int unsigned D = 4;
   localparam logic [63:0] MASK = (64'd1 << D) - 64'd1;

   logic       CLK = 1'b0;
   logic       RESET;
   logic       KEY_SELECT;
   logic       KEY_ZOOM;
   logic       ENABLE;
   logic       SELECT;
   logic       zoom_requested;
   logic [1:0] BTN_LEVEL;

   int errors = 0;
   int checks = 0;

   // Reference model state
   bit [7:0]  rh [2];
   bit [63:0] hs [2];
   int        hlen [2];
   bit        armed [2];
   bit        level [2];
   bit        commit [2];
   bit        pend;
   bit        e_sel;
   bit        e_zr;

   always #5 CLK = ~CLK;

   zoom_button_conditioner #(
      .DEBOUNCE_CYCLES (D),
      .BTN_ACTIVE_LOW  (1'b1),
      .REPEAT_DELAY    (8),
      .REPEAT_PERIOD   (4)
   ) dut (
      .CLK            (CLK),
      .RESET          (RESET),
      .KEY_SELECT     (KEY_SELECT),
      .KEY_ZOOM       (KEY_ZOOM),
      .ENABLE         (ENABLE),
      .SELECT         (SELECT),
      .zoom_requested (zoom_requested),
      .BTN_LEVEL      (BTN_LEVEL)
   );

   // A level change is accepted once the last D samples since the previous change all show the new level.
   task automatic tick(input bit rst, input bit ks, input bit kz, input bit en);
      bit raw [2];
      bit p;
      bit tgt;
      bit sf;
      bit zc;
      RESET      = rst;
      KEY_SELECT = ks;
      KEY_ZOOM   = kz;
      ENABLE     = en;
      raw[0] = ks;
      raw[1] = kz;
      @(posedge CLK);
      if (rst) begin
         for (int c = 0; c < 2; c++) begin
            rh[c] = 8'hFF; hs[c] = '0; hlen[c] = 0;
            armed[c] = 1'b0; level[c] = 1'b0; commit[c] = 1'b0;
         end
         pend = 1'b0; e_sel = 1'b0; e_zr = 1'b0;
      end else begin
         sf = commit[0] & en;
         zc = pend | (commit[1] & en);
         if (sf) begin
            e_sel = 1'b1; e_zr = 1'b0; pend = zc;
         end else begin
            e_sel = 1'b0; e_zr = zc; pend = 1'b0;
         end
         for (int c = 0; c < 2; c++) begin
            p = !rh[c][1];
            commit[c] = 1'b0;
            hs[c] = {hs[c][62:0], p};
            hlen[c]++;
            tgt = armed[c] ? !level[c] : 1'b0;
            if (hlen[c] >= D && (hs[c] & MASK) == (tgt ? MASK : 64'd0)) begin
               if (!armed[c]) armed[c] = 1'b1;
               else begin
                  level[c]  = !level[c];
                  commit[c] = level[c];
               end
               hlen[c] = 0;
            end
            rh[c] = {rh[c][6:0], raw[c]};
         end
      end
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         tick(1'b1, 1'b1, 1'b1, 1'b1);
         checks++;
         if ({SELECT, zoom_requested, BTN_LEVEL} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_values cyc=%0d got %b want 0000", i, {SELECT, zoom_requested, BTN_LEVEL});
         end
      end
      for (int i = 0; i < 10; i++) begin
         tick(1'b0, 1'b1, 1'b1, 1'b1);
         checks++;
         if ({SELECT, zoom_requested, BTN_LEVEL} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_idle cyc=%0d got %b want 0000", i, {SELECT, zoom_requested, BTN_LEVEL});
         end
      end
   endtask

   task automatic test_clean_press();
      int nsel = 0, nzr = 0, at = -1;
      for (int i = 0; i < 36; i++) begin
         tick(1'b0, !(i >= 2 && i < 22), 1'b1, 1'b1);
         if (SELECT === 1'b1) begin nsel++; at = i; end
         if (zoom_requested === 1'b1) nzr++;
         checks++;
         if ({SELECT, zoom_requested, BTN_LEVEL} !== {e_sel, e_zr, level[1], level[0]}) begin
            errors++;
            $display("FAIL clean_model cyc=%0d got %b want %b", i,
                     {SELECT, zoom_requested, BTN_LEVEL}, {e_sel, e_zr, level[1], level[0]});
         end
         if (i == 6 || i == 7 || i == 26 || i == 27) begin
            checks++;
            if (BTN_LEVEL[0] !== (i == 7 || i == 26)) begin
               errors++;
               $display("FAIL clean_level cyc=%0d got %b want %b", i, BTN_LEVEL[0], (i == 7 || i == 26));
            end
         end
      end
      checks++;
      if (nsel != 1 || at != 8) begin
         errors++;
         $display("FAIL clean_pulse got count=%0d at=%0d want count=1 at=8", nsel, at);
      end
      checks++;
      if (nzr != 0) begin
         errors++;
         $display("FAIL clean_no_zoom got %0d want 0", nzr);
      end
   endtask

   task automatic test_bounce();
      bit pat [12] = '{1, 1, 0, 0, 1, 0, 0, 1, 1, 1, 1, 1};
      int nzr = 0;
      for (int i = 0; i < 22; i++) begin
         tick(1'b0, 1'b1, (i < 12) ? pat[i] : 1'b1, 1'b1);
         if (zoom_requested === 1'b1) nzr++;
         checks++;
         if ({SELECT, zoom_requested, BTN_LEVEL} !== {e_sel, e_zr, level[1], level[0]}) begin
            errors++;
            $display("FAIL bounce_model cyc=%0d got %b want %b", i,
                     {SELECT, zoom_requested, BTN_LEVEL}, {e_sel, e_zr, level[1], level[0]});
         end
      end
      checks++;
      if (nzr != 0) begin
         errors++;
         $display("FAIL bounce_rejected got %0d want 0", nzr);
      end
      nzr = 0;
      for (int i = 0; i < 22; i++) begin
         tick(1'b0, 1'b1, !(i < 10), 1'b1);
         if (zoom_requested === 1'b1) nzr++;
      end
      checks++;
      if (nzr != 1) begin
         errors++;
         $display("FAIL bounce_clean_press got %0d want 1", nzr);
      end
   endtask

   task automatic test_held_reset();
      int nsel = 0;
      for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 30; i++) begin
         tick(1'b0, 1'b0, 1'b1, 1'b1);
         if (SELECT === 1'b1) nsel++;
         checks++;
         if ({SELECT, zoom_requested, BTN_LEVEL} !== {e_sel, e_zr, level[1], level[0]}) begin
            errors++;
            $display("FAIL held_model cyc=%0d got %b want %b", i,
                     {SELECT, zoom_requested, BTN_LEVEL}, {e_sel, e_zr, level[1], level[0]});
         end
      end
      checks++;
      if (nsel != 0 || BTN_LEVEL !== 2'b00) begin
         errors++;
         $display("FAIL held_no_pulse got count=%0d lvl=%b want count=0 lvl=00", nsel, BTN_LEVEL);
      end
      nsel = 0;
      for (int i = 0; i < 32; i++) begin
         tick(1'b0, !(i >= 10 && i < 20), 1'b1, 1'b1);
         if (SELECT === 1'b1) nsel++;
      end
      checks++;
      if (nsel != 1) begin
         errors++;
         $display("FAIL held_repress got %0d want 1", nsel);
      end
   endtask

   task automatic test_simultaneous();
      int nsel = 0, nzr = 0, ts = -1, tz = -1, both = 0;
      for (int i = 0; i < 30; i++) begin
         tick(1'b0, !(i >= 2 && i < 14), !(i >= 2 && i < 14), 1'b1);
         if (SELECT === 1'b1) begin nsel++; ts = i; end
         if (zoom_requested === 1'b1) begin nzr++; tz = i; end
         if (SELECT === 1'b1 && zoom_requested === 1'b1) both++;
         checks++;
         if ({SELECT, zoom_requested, BTN_LEVEL} !== {e_sel, e_zr, level[1], level[0]}) begin
            errors++;
            $display("FAIL simul_model cyc=%0d got %b want %b", i,
                     {SELECT, zoom_requested, BTN_LEVEL}, {e_sel, e_zr, level[1], level[0]});
         end
      end
      checks++;
      if (nsel != 1 || nzr != 1 || ts != 8 || tz != 9 || both != 0) begin
         errors++;
         $display("FAIL simul_order got sel=%0d@%0d zoom=%0d@%0d both=%0d want 1@8 1@9 both=0",
                  nsel, ts, nzr, tz, both);
      end
   endtask

   task automatic test_enable();
      int nsel = 0;
      for (int i = 0; i < 30; i++) begin
         tick(1'b0, !(i >= 2 && i < 20), 1'b1, (i >= 12));
         if (SELECT === 1'b1) nsel++;
         checks++;
         if ({SELECT, zoom_requested, BTN_LEVEL} !== {e_sel, e_zr, level[1], level[0]}) begin
            errors++;
            $display("FAIL enable_model cyc=%0d got %b want %b", i,
                     {SELECT, zoom_requested, BTN_LEVEL}, {e_sel, e_zr, level[1], level[0]});
         end
      end
      checks++;
      if (nsel != 0) begin
         errors++;
         $display("FAIL enable_dropped got %0d want 0", nsel);
      end
      nsel = 0;
      for (int i = 0; i < 22; i++) begin
         tick(1'b0, !(i < 10), 1'b1, 1'b1);
         if (SELECT === 1'b1) nsel++;
      end
      checks++;
      if (nsel != 1) begin
         errors++;
         $display("FAIL enable_repress got %0d want 1", nsel);
      end
   endtask

   task automatic test_random();
      bit ks = 1'b1, kz = 1'b1, en, rst;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 5) == 0) ks = !ks;
         if ($urandom_range(0, 5) == 0) kz = !kz;
         en  = ($urandom_range(0, 9) != 0);
         rst = ($urandom_range(0, 299) == 0);
         tick(rst, ks, kz, en);
         checks++;
         if ({SELECT, zoom_requested, BTN_LEVEL} !== {e_sel, e_zr, level[1], level[0]}) begin
            errors++;
            $display("FAIL random_model cyc=%0d got %b want %b", i,
                     {SELECT, zoom_requested, BTN_LEVEL}, {e_sel, e_zr, level[1], level[0]});
         end
         if (SELECT === 1'b1 && zoom_requested === 1'b1) begin
            errors++;
            $display("FAIL random_collision cyc=%0d got both high want exclusive", i);
         end
      end
   endtask

   initial begin
      RESET = 1'b1; KEY_SELECT = 1'b1; KEY_ZOOM = 1'b1; ENABLE = 1'b1;
      test_reset();
      test_clean_press();
      test_bounce();
      test_held_reset();
      test_simultaneous();
      test_enable();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
